// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared definitions for the PWM duty-cycle controller: FSM state
// encodings, the default duty width and the timer width helper.
package pwm_duty_ctrl_pkg;

  localparam int unsigned DUTY_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // Width of the hold/repeat timer: clog2 of the larger delay, at least 1 bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button/sync inputs and duty outputs of the PWM duty-cycle controller.
// master: the side driving buttons and the PWM sync; slave: the controller.
interface pwm_duty_ctrl_if import pwm_duty_ctrl_pkg::*; #(
  parameter int unsigned DUTY_W = DUTY_W_DEF
);
  logic              up_lvl;
  logic              dn_lvl;
  logic              pwm_sync;
  logic [DUTY_W-1:0] duty;
  logic [DUTY_W-1:0] duty_pend;
  logic              at_min;
  logic              at_max;
  logic              upd;

  modport master (
    output up_lvl, dn_lvl, pwm_sync,
    input  duty, duty_pend, at_min, at_max, upd
  );

  modport slave (
    input  up_lvl, dn_lvl, pwm_sync,
    output duty, duty_pend, at_min, at_max, upd
  );
endinterface

// File: rtl/pwm_duty_ctrl_rpt_timer.sv
// Hold / auto-repeat timer. Counts while enabled, clears on request and
// wraps to zero at the terminal count of the selected limit
// (sel = 0: HOLD_DLY, sel = 1: REPEAT_DLY).
module pwm_duty_ctrl_rpt_timer import pwm_duty_ctrl_pkg::*; #(
  parameter int unsigned HOLD_DLY   = 25_000_000,
  parameter int unsigned REPEAT_DLY = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel,
  output logic tc
);
  localparam int unsigned   TW        = timer_width(HOLD_DLY, REPEAT_DLY);
  localparam logic [TW-1:0] HOLD_TC   = TW'(HOLD_DLY - 1);
  localparam logic [TW-1:0] REPEAT_TC = TW'(REPEAT_DLY - 1);

  logic [TW-1:0] count;

  assign tc = (count == (sel ? REPEAT_TC : HOLD_TC));

  // Count up to the terminal value, then restart from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + TW'(1);
    end
  end
endmodule

// File: rtl/pwm_duty_ctrl.sv
// PWM duty-cycle controller: turns debounced up/down button levels into
// tap steps and hold auto-repeat steps, stages the new duty and commits it
// only on the PWM period boundary (pwm_sync).
// Optional macro DUTY_CTRL_WRAP_EN: steps wrap modulo DUTY_MAX+1 instead of
// saturating at 0 / DUTY_MAX.
module pwm_duty_ctrl import pwm_duty_ctrl_pkg::*; #(
  parameter int unsigned DUTY_W     = DUTY_W_DEF,
  parameter int unsigned DUTY_MAX   = 255,
  parameter int unsigned RESET_DUTY = 128,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_DLY   = 25_000_000,
  parameter int unsigned REPEAT_DLY = 5_000_000
) (
  input logic            clk,
  input logic            rst,
  pwm_duty_ctrl_if.slave bus
);
  localparam logic [DUTY_W-1:0] RESET_V = DUTY_W'(RESET_DUTY);
  localparam logic [DUTY_W-1:0] MAX_V   = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W:0]   MAX_X   = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W+1)'(STEP);
`ifdef DUTY_CTRL_WRAP_EN
  localparam logic [DUTY_W:0]   MOD_X   = (DUTY_W+1)'(DUTY_MAX + 1);
`endif

  state_e            state;
  logic              dir;
  logic              up_q;
  logic              dn_q;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] pend_r;
  logic              upd_r;

  logic rise_up;
  logic rise_dn;
  logic abort;
  logic tc;
  logic timer_clr;
  logic step_go;
  logic step_up;

  // One step of the staged duty, evaluated one bit wider than the duty.
  function automatic logic [DUTY_W-1:0] step_fn(input logic [DUTY_W-1:0] cur, input logic up);
    logic [DUTY_W:0] ext;
    logic [DUTY_W:0] sum;
    ext = {1'b0, cur};
    if (up) begin
      sum = ext + STEP_X;
`ifdef DUTY_CTRL_WRAP_EN
      if (sum > MAX_X) sum = sum - MOD_X;
`else
      if (sum > MAX_X) sum = MAX_X;
`endif
    end else if (ext < STEP_X) begin
`ifdef DUTY_CTRL_WRAP_EN
      sum = ext + MOD_X - STEP_X;
`else
      sum = '0;
`endif
    end else begin
      sum = ext - STEP_X;
    end
    return sum[DUTY_W-1:0];
  endfunction

  assign rise_up = bus.up_lvl & ~up_q;
  assign rise_dn = bus.dn_lvl & ~dn_q;
  // Leave a press when the held button is released or the other one joins.
  assign abort   = dir ? (~bus.up_lvl | bus.dn_lvl) : (~bus.dn_lvl | bus.up_lvl);

  // Decide this cycle's step and whether the timer restarts.
  always_comb begin
    step_go   = 1'b0;
    step_up   = dir;
    timer_clr = 1'b0;
    case (state)
      IDLE: begin
        timer_clr = 1'b1;
        if (rise_up && !bus.dn_lvl) begin
          step_go = 1'b1;
          step_up = 1'b1;
        end else if (rise_dn && !bus.up_lvl) begin
          step_go = 1'b1;
          step_up = 1'b0;
        end
      end
      PRESS, REPEAT: begin
        if (abort) timer_clr = 1'b1;
        else if (tc) step_go = 1'b1;
      end
      default: timer_clr = 1'b1;
    endcase
  end

  pwm_duty_ctrl_rpt_timer #(
    .HOLD_DLY   (HOLD_DLY),
    .REPEAT_DLY (REPEAT_DLY)
  ) u_rpt_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (state != IDLE),
    .sel (state == REPEAT),
    .tc  (tc)
  );

  // Button edge registers, FSM, staged duty and period-boundary commit.
  // The commit reads pend_r before this cycle's step lands, so a step that
  // coincides with pwm_sync is picked up on the following sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dir    <= 1'b0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      pend_r <= RESET_V;
      duty_r <= RESET_V;
      upd_r  <= 1'b0;
    end else begin
      up_q <= bus.up_lvl;
      dn_q <= bus.dn_lvl;
      case (state)
        IDLE: begin
          if (step_go) begin
            state <= PRESS;
            dir   <= step_up;
          end
        end
        PRESS: begin
          if (abort)   state <= IDLE;
          else if (tc) state <= REPEAT;
        end
        REPEAT: begin
          if (abort) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (step_go) pend_r <= step_fn(pend_r, step_up);
      if (bus.pwm_sync) duty_r <= pend_r;
      upd_r <= bus.pwm_sync && (pend_r != duty_r);
    end
  end

  assign bus.duty      = duty_r;
  assign bus.duty_pend = pend_r;
  assign bus.upd       = upd_r;
  assign bus.at_min    = (pend_r == '0);
  assign bus.at_max    = (pend_r == MAX_V);
endmodule
